mesi_cache_ctrl: RTL and testbench

Parametrised per-CPU coherence controller, successor to the per-line MSI cache FSM. Adds the Exclusive state, a request/done handshake on the processor side and request/grant arbitration on the shared bus. Adds snoop responses (shared, flush) and data-return waiting. One instance per CPU on the snooping bus; line state only, no data storage.

---
 rtl/mesi_cache_ctrl_pkg.sv | 58 +++++
 rtl/mesi_cache_ctrl_if.sv | 38 +++
 rtl/mesi_cache_ctrl_line_array.sv | 49 ++++
 rtl/mesi_cache_ctrl.sv | 124 ++++++++++++
 tb/tb_mesi_cache_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mesi_cache_ctrl_pkg.sv
// Shared encodings and the snoop transition function for the MESI controller.
package mesi_pkg;

   localparam logic [2:0] BUS_IDLE = 3'd0;
   localparam logic [2:0] BUS_RD   = 3'd1;
   localparam logic [2:0] BUS_RDX  = 3'd2;
   localparam logic [2:0] BUS_UPGR = 3'd3;

   typedef enum logic [1:0] {
      LINE_I = 2'd0,
      LINE_S = 2'd1,
      LINE_E = 2'd2,
      LINE_M = 2'd3
   } line_state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2,
      ST_WAIT = 2'd3
   } fsm_state_t;

   typedef struct packed {
      line_state_t nxt;
      logic        flush;
      logic        shared;
   } snoop_res_t;

   function automatic snoop_res_t mesi_snoop_next(line_state_t st, logic [2:0] msg);
      snoop_res_t r;
      r.nxt    = st;
      r.flush  = 1'b0;
      r.shared = 1'b0;
      case (st)
         LINE_M: begin
            if (msg == BUS_RD) begin
               r.nxt    = LINE_S;
               r.flush  = 1'b1;
               r.shared = 1'b1;
            end else if (msg == BUS_RDX) begin
               r.nxt   = LINE_I;
               r.flush = 1'b1;
            end
         end
         LINE_E, LINE_S: begin
            if (msg == BUS_RD) begin
               r.nxt    = LINE_S;
               r.shared = 1'b1;
            end else if (msg == BUS_RDX || msg == BUS_UPGR) begin
               r.nxt = LINE_I;
            end
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mesi_cache_ctrl_if.sv
// Processor-side handshake and snooping-bus signals of one coherence controller.
interface mesi_cache_ctrl_if #(
   parameter int ADDR_W = 2
);
   localparam int NUM_LINES = 2 ** ADDR_W;

   logic                   pr_req_i;
   logic                   pr_we_i;
   logic [ADDR_W-1:0]      pr_addr_i;
   logic                   pr_ready_o;
   logic                   pr_done_o;
   logic                   bus_req_o;
   logic                   bus_gnt_i;
   logic [2:0]             bus_msg_o;
   logic [ADDR_W-1:0]      bus_addr_o;
   logic [2:0]             bus_msg_i;
   logic [ADDR_W-1:0]      bus_addr_i;
   logic                   bus_shared_i;
   logic                   bus_shared_o;
   logic                   data_valid_i;
   logic                   flush_o;
   logic [2*NUM_LINES-1:0] line_state_o;

   modport master (
      input  pr_req_i, pr_we_i, pr_addr_i, bus_gnt_i, bus_msg_i, bus_addr_i,
             bus_shared_i, data_valid_i,
      output pr_ready_o, pr_done_o, bus_req_o, bus_msg_o, bus_addr_o,
             bus_shared_o, flush_o, line_state_o
   );

   modport slave (
      output pr_req_i, pr_we_i, pr_addr_i, bus_gnt_i, bus_msg_i, bus_addr_i,
             bus_shared_i, data_valid_i,
      input  pr_ready_o, pr_done_o, bus_req_o, bus_msg_o, bus_addr_o,
             bus_shared_o, flush_o, line_state_o
   );

endinterface

// File: rtl/mesi_cache_ctrl_line_array.sv
// Per-line MESI state registers with a snoop update path and a local update path.
module mesi_line_array
   import mesi_pkg::*;
#(
   parameter int ADDR_W = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            snoop_en,
   input  logic [ADDR_W-1:0]               snoop_addr,
   input  logic [2:0]                      snoop_msg,
   input  logic                            upd_en,
   input  logic [ADDR_W-1:0]               upd_addr,
   input  line_state_t                     upd_state,
   output line_state_t [2**ADDR_W-1:0]     adj,
   output logic [2*(2**ADDR_W)-1:0]        state_flat,
   output logic                            flush,
   output logic                            shared
);
   localparam int NUM_LINES = 2 ** ADDR_W;

   line_state_t [NUM_LINES-1:0] cur;
   snoop_res_t                  res;

   always_comb begin
      res    = mesi_snoop_next(cur[snoop_addr], snoop_msg);
      adj    = cur;
      flush  = 1'b0;
      shared = 1'b0;
      if (snoop_en) begin
         adj[snoop_addr] = res.nxt;
         flush           = res.flush;
         shared          = res.shared;
      end
   end

   // The local update is derived from adj, so it already accounts for any same-cycle snoop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) cur[i] <= LINE_I;
      end else begin
         cur <= adj;
         if (upd_en) cur[upd_addr] <= upd_state;
      end
   end

   assign state_flat = cur;

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Per-CPU MESI coherence controller: processor handshake, bus arbitration, snooping.
module mesi_cache_ctrl
   import mesi_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int CPU_ID = 0
) (
   input logic               clk_i,
   input logic               rst_i,
   mesi_cache_ctrl_if.master cif
);
   localparam int NUM_LINES = 2 ** ADDR_W;

   fsm_state_t                  state, state_nxt;
   logic                        op_we, op_we_nxt;
   logic [ADDR_W-1:0]           op_addr, op_addr_nxt;
   logic                        done_q, done_nxt;
   logic                        miss_done_q, miss_done_nxt;
   logic                        snoop_en, upd_en;
   logic [ADDR_W-1:0]           upd_addr;
   line_state_t                 upd_state;
   line_state_t [NUM_LINES-1:0] adj;
   line_state_t                 req_line, cur_line;
   logic [2:0]                  msg;

   assign snoop_en = (cif.bus_msg_i != BUS_IDLE) && !cif.bus_gnt_i;
   assign req_line = adj[cif.pr_addr_i];
   assign cur_line = adj[op_addr];

   mesi_line_array #(.ADDR_W(ADDR_W)) u_lines (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .snoop_en   (snoop_en),
      .snoop_addr (cif.bus_addr_i),
      .snoop_msg  (cif.bus_msg_i),
      .upd_en     (upd_en),
      .upd_addr   (upd_addr),
      .upd_state  (upd_state),
      .adj        (adj),
      .state_flat (cif.line_state_o),
      .flush      (cif.flush_o),
      .shared     (cif.bus_shared_o)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         op_we       <= 1'b0;
         op_addr     <= '0;
         done_q      <= 1'b0;
         miss_done_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         op_we       <= op_we_nxt;
         op_addr     <= op_addr_nxt;
         done_q      <= done_nxt;
         miss_done_q <= miss_done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      op_we_nxt     = op_we;
      op_addr_nxt   = op_addr;
      done_nxt      = 1'b0;
      miss_done_nxt = 1'b0;
      upd_en        = 1'b0;
      upd_addr      = op_addr;
      upd_state     = LINE_I;
      msg           = BUS_IDLE;
      case (state)
         ST_IDLE: begin
            if (cif.pr_req_i && !miss_done_q) begin
               op_we_nxt   = cif.pr_we_i;
               op_addr_nxt = cif.pr_addr_i;
               if (!cif.pr_we_i && req_line != LINE_I) begin
                  done_nxt = 1'b1;
               end else if (cif.pr_we_i && req_line == LINE_M) begin
                  done_nxt = 1'b1;
               end else if (cif.pr_we_i && req_line == LINE_E) begin
                  done_nxt  = 1'b1;
                  upd_en    = 1'b1;
                  upd_addr  = cif.pr_addr_i;
                  upd_state = LINE_M;
               end else begin
                  state_nxt = ST_ARB;
               end
            end
         end
         ST_ARB: if (cif.bus_gnt_i) state_nxt = ST_XFER;
         ST_XFER: begin
            // A line snooped away to I while arbitrating must refetch with RDX.
            if (op_we && cur_line == LINE_S) begin
               msg           = BUS_UPGR;
               upd_en        = 1'b1;
               upd_state     = LINE_M;
               done_nxt      = 1'b1;
               miss_done_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end else begin
               msg       = op_we ? BUS_RDX : BUS_RD;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cif.data_valid_i) begin
               upd_en        = 1'b1;
               upd_state     = op_we ? LINE_M : (cif.bus_shared_i ? LINE_S : LINE_E);
               done_nxt      = 1'b1;
               miss_done_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign cif.pr_ready_o = rst_i && (state == ST_IDLE) && !miss_done_q;
   assign cif.pr_done_o  = done_q;
   assign cif.bus_req_o  = (state != ST_IDLE);
   assign cif.bus_msg_o  = msg;
   assign cif.bus_addr_o = (state == ST_XFER) ? op_addr : '0;

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed bench for mesi_cache_ctrl: misses, hits, snoops, upgrade, reset abort.
module tb_mesi_cache_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mesi_cache_ctrl_if #(.ADDR_W(2)) ifc ();

   mesi_cache_ctrl #(.ADDR_W(2), .CPU_ID(0)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .cif   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ln(input int a);
      return {30'd0, ifc.line_state_o[2*a +: 2]};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      ifc.pr_req_i = 0; ifc.pr_we_i = 0; ifc.pr_addr_i = 0;
      ifc.bus_gnt_i = 0; ifc.bus_msg_i = 0; ifc.bus_addr_i = 0;
      ifc.bus_shared_i = 0; ifc.data_valid_i = 0;
      #2;
      chk("rst_ready", ifc.pr_ready_o, 0);
      chk("rst_lines", ifc.line_state_o, 0);
      chk("rst_busreq", ifc.bus_req_o, 0);
      chk("rst_done", ifc.pr_done_o, 0);
      chk("rst_msg", ifc.bus_msg_o, 0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", ifc.pr_ready_o, 1);

      // read miss on line 1, no sharers -> E
      tick();
      ifc.pr_req_i = 1; ifc.pr_we_i = 0; ifc.pr_addr_i = 1;
      #1 chk("rm_idle_busreq", ifc.bus_req_o, 0);
      tick();
      ifc.pr_req_i = 0;
      #1 chk("rm_arb_busreq", ifc.bus_req_o, 1);
      chk("rm_arb_msg", ifc.bus_msg_o, 0);
      chk("rm_arb_ready", ifc.pr_ready_o, 0);
      ifc.bus_gnt_i = 1;
      tick();
      ifc.bus_gnt_i = 0;
      #1 chk("rm_xfer_msg", ifc.bus_msg_o, 1);
      chk("rm_xfer_addr", ifc.bus_addr_o, 1);
      tick();
      #1 chk("rm_wait_msg", ifc.bus_msg_o, 0);
      chk("rm_wait_addr", ifc.bus_addr_o, 0);
      chk("rm_wait_busreq", ifc.bus_req_o, 1);
      chk("rm_wait_done", ifc.pr_done_o, 0);
      ifc.data_valid_i = 1; ifc.bus_shared_i = 0;
      tick();
      ifc.data_valid_i = 0;
      #1 chk("rm_done", ifc.pr_done_o, 1);
      chk("rm_line1_E", ln(1), 2);
      chk("rm_done_ready", ifc.pr_ready_o, 0);
      chk("rm_done_busreq", ifc.bus_req_o, 0);
      tick();
      #1 chk("rm_done_pulse", ifc.pr_done_o, 0);
      chk("rm_ready_back", ifc.pr_ready_o, 1);

      // write hit on E line 1 -> M silently
      ifc.pr_req_i = 1; ifc.pr_we_i = 1; ifc.pr_addr_i = 1;
      tick();
      ifc.pr_req_i = 0;
      #1 chk("wh_line1_M", ln(1), 3);
      chk("wh_done", ifc.pr_done_o, 1);
      chk("wh_busreq", ifc.bus_req_o, 0);
      tick();
      #1 chk("wh_done_pulse", ifc.pr_done_o, 0);

      // snoop RD on M line 1 -> flush, shared, S
      ifc.bus_msg_i = 1; ifc.bus_addr_i = 1;
      #1 chk("snrd_flush", ifc.flush_o, 1);
      chk("snrd_shared", ifc.bus_shared_o, 1);
      chk("snrd_line1_still_M", ln(1), 3);
      tick();
      ifc.bus_msg_i = 0;
      #1 chk("snrd_line1_S", ln(1), 1);
      chk("snrd_flush_off", ifc.flush_o, 0);

      // read hit on S line 1
      ifc.pr_req_i = 1; ifc.pr_we_i = 0; ifc.pr_addr_i = 1;
      tick();
      ifc.pr_req_i = 0;
      #1 chk("rh_done", ifc.pr_done_o, 1);
      chk("rh_busreq", ifc.bus_req_o, 0);
      tick();

      // read miss on line 2 with sharers -> S
      ifc.pr_req_i = 1; ifc.pr_we_i = 0; ifc.pr_addr_i = 2;
      tick();
      ifc.pr_req_i = 0; ifc.bus_gnt_i = 1;
      tick();
      ifc.bus_gnt_i = 0;
      tick();
      ifc.data_valid_i = 1; ifc.bus_shared_i = 1;
      tick();
      ifc.data_valid_i = 0; ifc.bus_shared_i = 0;
      #1 chk("rms_line2_S", ln(2), 1);
      tick();

      // write on S line 2 -> UPGR, no data wait
      ifc.pr_req_i = 1; ifc.pr_we_i = 1; ifc.pr_addr_i = 2;
      tick();
      ifc.pr_req_i = 0;
      #1 chk("up_arb_busreq", ifc.bus_req_o, 1);
      ifc.bus_gnt_i = 1;
      tick();
      ifc.bus_gnt_i = 0;
      #1 chk("up_xfer_msg", ifc.bus_msg_o, 3);
      chk("up_xfer_addr", ifc.bus_addr_o, 2);
      tick();
      #1 chk("up_done", ifc.pr_done_o, 1);
      chk("up_line2_M", ln(2), 3);
      chk("up_busreq_off", ifc.bus_req_o, 0);
      chk("up_msg_idle", ifc.bus_msg_o, 0);
      tick();
      #1 chk("up_done_pulse", ifc.pr_done_o, 0);

      // bring line 2 back to S via snoop RD, then lose it to RDX while in ARB
      ifc.bus_msg_i = 1; ifc.bus_addr_i = 2;
      #1 chk("sn2_flush", ifc.flush_o, 1);
      tick();
      ifc.bus_msg_i = 0;
      #1 chk("sn2_line2_S", ln(2), 1);
      ifc.pr_req_i = 1; ifc.pr_we_i = 1; ifc.pr_addr_i = 2;
      tick();
      ifc.pr_req_i = 0;
      ifc.bus_msg_i = 2; ifc.bus_addr_i = 2;
      #1 chk("rdx_snoop_shared", ifc.bus_shared_o, 0);
      chk("rdx_snoop_flush", ifc.flush_o, 0);
      tick();
      ifc.bus_msg_i = 0;
      #1 chk("rdx_line2_I", ln(2), 0);
      chk("rdx_arb_busreq", ifc.bus_req_o, 1);
      ifc.bus_gnt_i = 1;
      tick();
      ifc.bus_gnt_i = 0;
      #1 chk("rdx_xfer_msg", ifc.bus_msg_o, 2);
      chk("rdx_xfer_addr", ifc.bus_addr_o, 2);
      tick();
      #1 chk("rdx_wait_done", ifc.pr_done_o, 0);
      ifc.data_valid_i = 1;
      tick();
      ifc.data_valid_i = 0;
      #1 chk("rdx_done", ifc.pr_done_o, 1);
      chk("rdx_line2_M", ln(2), 3);
      tick();

      // data_valid outside WAIT is ignored
      ifc.data_valid_i = 1;
      tick();
      ifc.data_valid_i = 0;
      #1 chk("dv_idle_done", ifc.pr_done_o, 0);
      chk("dv_idle_lines", ifc.line_state_o, 32'h34);

      // reset pulse during WAIT aborts the read miss on line 3
      ifc.pr_req_i = 1; ifc.pr_we_i = 0; ifc.pr_addr_i = 3;
      tick();
      ifc.pr_req_i = 0; ifc.bus_gnt_i = 1;
      tick();
      ifc.bus_gnt_i = 0;
      tick();
      #1 chk("ra_wait_busreq", ifc.bus_req_o, 1);
      rst_n = 1'b0;
      #1 chk("ra_busreq_drop", ifc.bus_req_o, 0);
      chk("ra_lines_clear", ifc.line_state_o, 0);
      chk("ra_ready_low", ifc.pr_ready_o, 0);
      chk("ra_done_low", ifc.pr_done_o, 0);
      ifc.data_valid_i = 1;
      tick();
      ifc.data_valid_i = 0;
      tick();
      rst_n = 1'b1;
      #1 chk("ra_ready_after", ifc.pr_ready_o, 1);
      chk("ra_done_after", ifc.pr_done_o, 0);
      tick();
      #1 chk("ra_no_done", ifc.pr_done_o, 0);
      chk("ra_idle_busreq", ifc.bus_req_o, 0);
      chk("ra_lines_still_clear", ifc.line_state_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
